// File: rtl/fifo_pkg.sv
// Shared types and Gray-code helpers for the dual-clock FIFO.
// Pointers of any width up to PTR_MAX are zero-extended into ptr_t.
package fifo_pkg;

    localparam int PTR_MAX = 16;

    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchroniser for a Gray-coded bus.
// Only one bit changes per source update, so the bus lands coherently.
module cdc_sync_bus #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the source bus through STAGES destination-clocked flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointers crossing through synchronisers.
// Registered full/empty, per-domain levels, almost flags, sticky errors.
module async_fifo_gray
    import fifo_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_MARGIN   = 1,
    parameter int AE_MARGIN   = 1
) (
    input  logic                   wclk,
    input  logic                   reset_w,
    input  logic                   rclk,
    input  logic                   reset_r,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    output logic                   full,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] wlevel,
    output logic                   overflow,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] rlevel,
    output logic                   underflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int PADW = PTR_MAX - PW;

    // Top two Gray bits inverted marks a pointer exactly DEPTH ahead
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (AW - 1);
    localparam logic [PW-1:0] AF_LEVEL  = PW'(DEPTH - AF_MARGIN);
    localparam logic [PW-1:0] AE_LEVEL  = PW'(AE_MARGIN);

    logic [WIDTH-1:0] mem [DEPTH];

    logic          w_accept;
    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] wptr_gray;
    logic [PW-1:0] wptr_bin_next;
    logic [PW-1:0] wptr_gray_next;
    logic [PW-1:0] wq_rptr_gray;
    logic [PW-1:0] wq_rptr_bin;
    logic [PW-1:0] wlevel_next;
    logic          full_next;
    logic          almost_full_next;

    logic          r_accept;
    logic [PW-1:0] rptr_bin;
    logic [PW-1:0] rptr_gray;
    logic [PW-1:0] rptr_bin_next;
    logic [PW-1:0] rptr_gray_next;
    logic [PW-1:0] rq_wptr_gray;
    logic [PW-1:0] rq_wptr_bin;
    logic [PW-1:0] rlevel_next;
    logic          empty_next;
    logic          almost_empty_next;

    cdc_sync_bus #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_r2w (
        .clk   (wclk),
        .reset (reset_w),
        .d     (rptr_gray),
        .q     (wq_rptr_gray)
    );

    cdc_sync_bus #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_w2r (
        .clk   (rclk),
        .reset (reset_r),
        .d     (wptr_gray),
        .q     (rq_wptr_gray)
    );

    // Write side: next pointer, flags and level seen against synced rptr
    assign w_accept       = push && !full;
    assign wptr_bin_next  = wptr_bin + {{AW{1'b0}}, w_accept};
    assign wptr_gray_next = PW'(bin2gray({{PADW{1'b0}}, wptr_bin_next}));
    assign wq_rptr_bin    = PW'(gray2bin({{PADW{1'b0}}, wq_rptr_gray}));
    assign wlevel_next    = wptr_bin_next - wq_rptr_bin;
    assign full_next      = wptr_gray_next == (wq_rptr_gray ^ FULL_MASK);
    assign almost_full_next = wlevel_next >= AF_LEVEL;

    // Read side: next pointer, flags and level seen against synced wptr
    assign r_accept       = pop && !empty;
    assign rptr_bin_next  = rptr_bin + {{AW{1'b0}}, r_accept};
    assign rptr_gray_next = PW'(bin2gray({{PADW{1'b0}}, rptr_bin_next}));
    assign rq_wptr_bin    = PW'(gray2bin({{PADW{1'b0}}, rq_wptr_gray}));
    assign rlevel_next    = rq_wptr_bin - rptr_bin_next;
    assign empty_next     = rptr_gray_next == rq_wptr_gray;
    assign almost_empty_next = rlevel_next <= AE_LEVEL;

    // Storage is written only on accepted pushes and is never reset
    always_ff @(posedge wclk) begin
        if (w_accept) begin
            mem[wptr_bin[AW-1:0]] <= wdata;
        end
    end

    // First-word fall-through: head entry is visible without a read cycle
    assign rdata = mem[rptr_bin[AW-1:0]];

    // Write-domain pointer and flag registers
    always_ff @(posedge wclk or posedge reset_w) begin
        if (reset_w) begin
            wptr_bin    <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
            overflow    <= 1'b0;
        end else begin
            wptr_bin    <= wptr_bin_next;
            wptr_gray   <= wptr_gray_next;
            full        <= full_next;
            almost_full <= almost_full_next;
            wlevel      <= wlevel_next;
            if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Read-domain pointer and flag registers
    always_ff @(posedge rclk or posedge reset_r) begin
        if (reset_r) begin
            rptr_bin     <= '0;
            rptr_gray    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rlevel       <= '0;
            underflow    <= 1'b0;
        end else begin
            rptr_bin     <= rptr_bin_next;
            rptr_gray    <= rptr_gray_next;
            empty        <= empty_next;
            almost_empty <= almost_empty_next;
            rlevel       <= rlevel_next;
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_gray.sv
// Directed and randomized checks of async_fifo_gray against a queue model.
// Covers reset, ordering, latency, drop/sticky errors, ratios, almost flags.
module tb_async_fifo_gray;

    localparam int SYNC = 2;
    localparam int N    = 24;

    logic wclk = 1'b1;
    logic rclk = 1'b0;
    int   w_half = 5;
    int   r_half = 7;

    always #(w_half) wclk = ~wclk;
    always #(r_half) rclk = ~rclk;

    logic       reset_w = 1'b1;
    logic       reset_r = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       full, almost_full, overflow;
    logic       empty, almost_empty, underflow;
    logic [2:0] wlevel, rlevel;
    logic [7:0] rdata;

    logic       push8 = 1'b0;
    logic       pop8 = 1'b0;
    logic [7:0] wdata8 = 8'h00;
    logic       full8, almost_full8, overflow8;
    logic       empty8, almost_empty8, underflow8;
    logic [3:0] wlevel8, rlevel8;
    logic [7:0] rdata8;

    async_fifo_gray u0 (
        .wclk         (wclk),
        .reset_w      (reset_w),
        .rclk         (rclk),
        .reset_r      (reset_r),
        .push         (push),
        .wdata        (wdata),
        .full         (full),
        .almost_full  (almost_full),
        .wlevel       (wlevel),
        .overflow     (overflow),
        .pop          (pop),
        .rdata        (rdata),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rlevel       (rlevel),
        .underflow    (underflow)
    );

    async_fifo_gray #(
        .DEPTH     (8),
        .AF_MARGIN (2),
        .AE_MARGIN (2)
    ) u8 (
        .wclk         (wclk),
        .reset_w      (reset_w),
        .rclk         (rclk),
        .reset_r      (reset_r),
        .push         (push8),
        .wdata        (wdata8),
        .full         (full8),
        .almost_full  (almost_full8),
        .wlevel       (wlevel8),
        .overflow     (overflow8),
        .pop          (pop8),
        .rdata        (rdata8),
        .empty        (empty8),
        .almost_empty (almost_empty8),
        .rlevel       (rlevel8),
        .underflow    (underflow8)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] model [$];
    logic [7:0] v2 [4];
    logic [7:0] v4 [5];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_both();
        reset_w = 1'b1;
        reset_r = 1'b1;
        repeat (6) @(negedge wclk);
        repeat (6) @(negedge rclk);
        @(negedge wclk);
        reset_w = 1'b0;
        @(negedge rclk);
        reset_r = 1'b0;
        repeat (3) @(negedge wclk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, lat, acc, got, wc, rc;
        logic doit, dopop;

        v2 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        v4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // 1: reset state, during and after reset
        repeat (6) @(negedge rclk);
        check("rst_in_full", full, 0);
        check("rst_in_empty", empty, 1);
        @(negedge wclk);
        reset_w = 1'b0;
        @(negedge rclk);
        reset_r = 1'b0;
        repeat (4) @(negedge wclk);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_wlevel", wlevel, 0);
        check("rst_overflow", overflow, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", almost_empty, 1);
        check("rst_rlevel", rlevel, 0);
        check("rst_underflow", underflow, 0);
        check("rst8_empty", empty8, 1);
        check("rst8_full", full8, 0);

        // 2: fill to full, then drain in order
        for (int i = 0; i < 4; i++) begin
            @(negedge wclk);
            check("t2_full", full, 0);
            check("t2_wlevel", wlevel, i);
            check("t2_afull", almost_full, i >= 3);
            push  = 1'b1;
            wdata = v2[i];
        end
        @(negedge wclk);
        push = 1'b0;
        check("t2_full_4th", full, 1);
        check("t2_wlevel_4", wlevel, 4);
        check("t2_afull_4", almost_full, 1);
        n = 0;
        while (empty && n < 20) begin
            @(negedge rclk);
            n++;
        end
        check("t2_fill", empty, 0);
        repeat (4) @(negedge rclk);
        check("t2_rlevel", rlevel, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            check("t2_rdata", rdata, v2[i]);
            check("t2_empty", empty, 0);
            check("t2_rlevel_i", rlevel, 4 - i);
            check("t2_aempty", almost_empty, (4 - i) <= 1);
            pop = 1'b1;
        end
        @(negedge rclk);
        pop = 1'b0;
        check("t2_empty_end", empty, 1);
        check("t2_rlevel_end", rlevel, 0);
        check("t2_underflow", underflow, 0);
        repeat (6) @(negedge wclk);
        check("t2_full_clear", full, 0);
        check("t2_wlevel_end", wlevel, 0);

        // 3: single push, empty latency and fall-through data
        @(negedge wclk);
        push  = 1'b1;
        wdata = 8'h5A;
        lat   = 0;
        fork
            begin
                @(negedge wclk);
                push = 1'b0;
            end
            begin
                @(posedge wclk);
                do begin
                    @(posedge rclk);
                    lat++;
                    @(negedge rclk);
                end while (empty && lat < 10);
            end
        join
        check("t3_empty", empty, 0);
        check("t3_latency", lat <= SYNC + 1, 1);
        check("t3_rdata", rdata, 8'h5A);
        check("t3_rlevel", rlevel, 1);
        check("t3_aempty", almost_empty, 1);
        @(negedge rclk);
        pop = 1'b1;
        @(negedge rclk);
        pop = 1'b0;
        check("t3_empty_end", empty, 1);

        // 4: overflow drop, sticky flag, then underflow
        repeat (8) @(negedge wclk);
        for (int i = 0; i < 5; i++) begin
            @(negedge wclk);
            check("t4_full", full, i == 4);
            if (i == 4) check("t4_ovf_pre", overflow, 0);
            push  = 1'b1;
            wdata = v4[i];
        end
        @(negedge wclk);
        push = 1'b0;
        check("t4_overflow", overflow, 1);
        check("t4_wlevel", wlevel, 4);
        check("t4_full_hold", full, 1);
        repeat (8) @(negedge rclk);
        for (int i = 0; i < 4; i++) begin
            @(negedge rclk);
            check("t4_rdata", rdata, v4[i]);
            pop = 1'b1;
        end
        @(negedge rclk);
        pop = 1'b0;
        check("t4_empty", empty, 1);
        check("t4_udf_pre", underflow, 0);
        @(negedge rclk);
        pop = 1'b1;
        @(negedge rclk);
        pop = 1'b0;
        check("t4_underflow", underflow, 1);
        check("t4_rlevel", rlevel, 0);
        repeat (8) @(negedge wclk);
        check("t4_full_clear", full, 0);
        push  = 1'b1;
        wdata = 8'h77;
        @(negedge wclk);
        push = 1'b0;
        check("t4_ovf_sticky", overflow, 1);
        n = 0;
        while (empty && n < 20) begin
            @(negedge rclk);
            n++;
        end
        check("t4_after_empty", empty, 0);
        check("t4_after_rdata", rdata, 8'h77);
        check("t4_udf_sticky", underflow, 1);
        pop = 1'b1;
        @(negedge rclk);
        pop = 1'b0;
        check("t4_after_drain", empty, 1);

        // 5: random traffic at 3:7 and 7:3 clock ratios
        for (int r = 0; r < 2; r++) begin
            w_half = (r == 0) ? 3 : 7;
            r_half = (r == 0) ? 7 : 3;
            reset_both();
            model.delete();
            check("t5_ovf_reset", overflow, 0);
            check("t5_udf_reset", underflow, 0);
            acc = 0;
            got = 0;
            fork
                begin
                    wc = 0;
                    while (acc < N && wc < 1500) begin
                        @(negedge wclk);
                        wc++;
                        if (model.size() == 4)
                            check("t5_full_at_depth", full, 1);
                        doit  = ($urandom_range(0, 1) == 1);
                        push  = doit;
                        wdata = 8'($urandom);
                        if (doit && !full) begin
                            model.push_back(wdata);
                            acc++;
                        end
                    end
                    @(negedge wclk);
                    push = 1'b0;
                end
                begin
                    rc = 0;
                    while (got < N && rc < 3000) begin
                        @(negedge rclk);
                        rc++;
                        if (model.size() == 0)
                            check("t5_empty_drained", empty, 1);
                        if (!empty && model.size() > 0)
                            check("t5_order", rdata, model[0]);
                        dopop = ($urandom_range(0, 1) == 1);
                        pop   = dopop;
                        if (dopop && !empty) begin
                            void'(model.pop_front());
                            got++;
                        end
                    end
                    @(negedge rclk);
                    pop = 1'b0;
                end
            join
            check("t5_pushed", acc, N);
            check("t5_popped", got, N);
            check("t5_model_left", model.size(), 0);
        end

        // 6: DEPTH=8 almost flags at margin 2
        w_half = 5;
        r_half = 7;
        reset_both();
        for (int k = 0; k < 7; k++) begin
            @(negedge wclk);
            check("t6_wlevel", wlevel8, k);
            check("t6_afull", almost_full8, k >= 6);
            push8  = 1'b1;
            wdata8 = 8'h30 + 8'(k);
        end
        @(negedge wclk);
        push8 = 1'b0;
        check("t6_wlevel_7", wlevel8, 7);
        check("t6_afull_7", almost_full8, 1);
        check("t6_full_7", full8, 0);
        repeat (6) @(negedge rclk);
        for (int i = 0; i < 7; i++) begin
            @(negedge rclk);
            check("t6_rlevel", rlevel8, 7 - i);
            check("t6_aempty", almost_empty8, (7 - i) <= 2);
            check("t6_rdata", rdata8, 8'h30 + 8'(i));
            pop8 = 1'b1;
        end
        @(negedge rclk);
        pop8 = 1'b0;
        check("t6_empty", empty8, 1);
        check("t6_rlevel_0", rlevel8, 0);
        check("t6_aempty_0", almost_empty8, 1);
        repeat (8) @(negedge wclk);
        check("t6_wlevel_0", wlevel8, 0);
        check("t6_afull_0", almost_full8, 0);
        check("t6_ovf", overflow8, 0);
        check("t6_udf", underflow8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
